// File: rtl/id_ex_reg_pkg.sv
// Shared MIPS pipeline definitions: control-word layout, field encodings and
// small decode helpers used by the ID/EX register and its hazard logic.
package id_ex_reg_pkg;

   localparam int CTRL_W = 22;

   // Bit positions inside the packed controller word, MSB first.
   localparam int CTRL_REGWRITE    = 21;
   localparam int CTRL_BRANCH      = 20;
   localparam int CTRL_BCMP_HI     = 19;
   localparam int CTRL_BCMP_LO     = 17;
   localparam int CTRL_JUMP        = 16;
   localparam int CTRL_MEMREAD     = 15;
   localparam int CTRL_MEMWRITE    = 14;
   localparam int CTRL_MEMTOREG_HI = 13;
   localparam int CTRL_MEMTOREG_LO = 12;
   localparam int CTRL_JUMPSRC     = 11;
   localparam int CTRL_ALUSRC1     = 10;
   localparam int CTRL_ALUSRC2     = 9;
   localparam int CTRL_ALUOP_HI    = 8;
   localparam int CTRL_ALUOP_LO    = 4;
   localparam int CTRL_REGDST_HI   = 3;
   localparam int CTRL_REGDST_LO   = 2;
   localparam int CTRL_LUIOP       = 1;
   localparam int CTRL_EXTOP       = 0;

   // All-zero word: no RegWrite, MemRead, MemWrite, Branch or Jump.
   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 22'h000000;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_NOR  = 5'd5,
      ALU_SLT  = 5'd6,
      ALU_SLTU = 5'd7,
      ALU_SLL  = 5'd8,
      ALU_SRL  = 5'd9,
      ALU_SRA  = 5'd10,
      ALU_ADDU = 5'd11,
      ALU_SUBU = 5'd12,
      ALU_LUI  = 5'd13
   } alu_op_e;

   typedef enum logic [2:0] {
      BCMP_EQ   = 3'd0,
      BCMP_NE   = 3'd1,
      BCMP_LEZ  = 3'd2,
      BCMP_GTZ  = 3'd3,
      BCMP_LTZ  = 3'd4,
      BCMP_GEZ  = 3'd5
   } bcmp_e;

   typedef enum logic [1:0] {
      M2R_ALU  = 2'd0,
      M2R_MEM  = 2'd1,
      M2R_PC4  = 2'd2
   } memtoreg_e;

   typedef enum logic [1:0] {
      RDST_RT  = 2'd0,
      RDST_RD  = 2'd1,
      RDST_RA  = 2'd2
   } regdst_e;

   function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

   function automatic logic [4:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
   endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard detector: compares the load in EX against the
// source specifiers of the instruction sitting in ID.
module load_use_detect
   import id_ex_reg_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic       ex_valid,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       flush_i,
   output logic       haz,
   output logic       stall_o
);

   logic match_s;

   // Both specifiers are compared for every opcode; a spurious stall is harmless.
   always_comb begin
      match_s = 1'b0;
      if ((ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
         match_s = 1'b1;
      end else begin
         match_s = 1'b0;
      end
   end

   // A killed ID instruction never needs to wait for the load.
   always_comb begin
      haz     = ex_mem_read & ex_valid & match_s;
      stall_o = haz & ~flush_i;
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble injection, flush kill and
// saturating bubble/flush performance counters.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [21:0]       id_ctrl,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic [4:0]        id_shamt,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              hold_i,
   input  logic              flush_i,
   output logic [21:0]       ex_ctrl,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [15:0]       ex_imm,
   output logic [4:0]        ex_shamt,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic              ex_valid,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CTRL_W-1:0] ctrl_r;
   logic [DATA_W-1:0] pc4_r;
   logic [DATA_W-1:0] rs_data_r;
   logic [DATA_W-1:0] rt_data_r;
   logic [15:0]       imm_r;
   logic [4:0]        shamt_r;
   logic [4:0]        rs_r;
   logic [4:0]        rt_r;
   logic [4:0]        rd_r;
   logic              valid_r;
   logic [CNT_W-1:0]  bubble_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;

   logic              haz_s;
   logic              stall_s;
   logic              capture_s;
   logic [CNT_W-1:0]  bubble_inc_s;
   logic [CNT_W-1:0]  flush_inc_s;

   load_use_detect u_lud (
      .ex_mem_read (ctrl_mem_read(ctrl_r)),
      .ex_valid    (valid_r),
      .ex_rt       (rt_r),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .flush_i     (flush_i),
      .haz         (haz_s),
      .stall_o     (stall_s)
   );

   // Saturating next values for both performance counters.
   always_comb begin
      bubble_inc_s = bubble_cnt_r;
      flush_inc_s  = flush_cnt_r;
      if (bubble_cnt_r == CNT_MAX) begin
         bubble_inc_s = bubble_cnt_r;
      end else begin
         bubble_inc_s = bubble_cnt_r + CNT_ONE;
      end
      if (flush_cnt_r == CNT_MAX) begin
         flush_inc_s = flush_cnt_r;
      end else begin
         flush_inc_s = flush_cnt_r + CNT_ONE;
      end
   end

   // Data fields follow ID unless a hold freezes EX; a flush overrides the hold.
   always_comb begin
      capture_s = 1'b0;
      if (flush_i || !hold_i) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end
   end

   // Control word, valid flag and counters: flush > hold > hazard > capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_r       <= CTRL_BUBBLE;
         valid_r      <= 1'b0;
         bubble_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r  <= {CNT_W{1'b0}};
      end else if (flush_i) begin
         ctrl_r      <= CTRL_BUBBLE;
         valid_r     <= 1'b0;
         flush_cnt_r <= flush_inc_s;
      end else if (hold_i) begin
         ctrl_r  <= ctrl_r;
         valid_r <= valid_r;
      end else if (haz_s) begin
         ctrl_r       <= CTRL_BUBBLE;
         valid_r      <= 1'b0;
         bubble_cnt_r <= bubble_inc_s;
      end else begin
         ctrl_r  <= id_ctrl;
         valid_r <= 1'b1;
      end
   end

   // Operand and specifier fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc4_r     <= {DATA_W{1'b0}};
         rs_data_r <= {DATA_W{1'b0}};
         rt_data_r <= {DATA_W{1'b0}};
         imm_r     <= 16'h0000;
         shamt_r   <= 5'd0;
         rs_r      <= 5'd0;
         rt_r      <= 5'd0;
         rd_r      <= 5'd0;
      end else if (capture_s) begin
         pc4_r     <= id_pc4;
         rs_data_r <= id_rs_data;
         rt_data_r <= id_rt_data;
         imm_r     <= id_imm;
         shamt_r   <= id_shamt;
         rs_r      <= id_rs;
         rt_r      <= id_rt;
         rd_r      <= id_rd;
      end else begin
         pc4_r     <= pc4_r;
         rs_data_r <= rs_data_r;
         rt_data_r <= rt_data_r;
         imm_r     <= imm_r;
         shamt_r   <= shamt_r;
         rs_r      <= rs_r;
         rt_r      <= rt_r;
         rd_r      <= rd_r;
      end
   end

   assign ex_ctrl    = ctrl_r;
   assign ex_pc4     = pc4_r;
   assign ex_rs_data = rs_data_r;
   assign ex_rt_data = rt_data_r;
   assign ex_imm     = imm_r;
   assign ex_shamt   = shamt_r;
   assign ex_rs      = rs_r;
   assign ex_rt      = rt_r;
   assign ex_rd      = rd_r;
   assign ex_valid   = valid_r;
   assign stall_o    = stall_s;
   assign bubble_cnt = bubble_cnt_r;
   assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, capture, load-use bubble, zero register,
// flush priority, hold behaviour, counter saturation and async reset.
module tb_id_ex_reg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   // lw: RegWrite, MemRead, MemtoReg=01, ALUSrc2, ALUOp=add, ExtOp
   localparam logic [21:0] CTRL_LW  = 22'h209201;
   // add: RegWrite, RegDst=01, ALUOp=add
   localparam logic [21:0] CTRL_ADD = 22'h200004;

   logic              clk;
   logic              rst_n;
   logic [21:0]       id_ctrl;
   logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data;
   logic [15:0]       id_imm;
   logic [4:0]        id_shamt, id_rs, id_rt, id_rd;
   logic              hold_i, flush_i;
   logic [21:0]       ex_ctrl;
   logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data;
   logic [15:0]       ex_imm;
   logic [4:0]        ex_shamt, ex_rs, ex_rt, ex_rd;
   logic              ex_valid, stall_o;
   logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   id_ex_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .hold_i(hold_i), .flush_i(flush_i), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .stall_o(stall_o), .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present an instruction in ID; operand data is derived from pc4.
   task automatic drive_id(input logic [21:0] c, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] pc4);
      id_ctrl    = c;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_pc4     = pc4;
      id_rs_data = pc4 ^ 32'hA5A5_0000;
      id_rt_data = pc4 ^ 32'h0000_5A5A;
      id_imm     = pc4[15:0] + 16'h0010;
      id_shamt   = pc4[6:2];
      #1;
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      hold_i  = 1'b0;
      flush_i = 1'b0;
      drive_id(22'h000000, 5'd0, 5'd0, 5'd0, 32'h0);
      tick();
      tick();
      check("rst_ctrl",   ex_ctrl, 22'h0);
      check("rst_valid",  ex_valid, 1'b0);
      check("rst_pc4",    ex_pc4, 32'h0);
      check("rst_bubble", bubble_cnt, 4'd0);
      check("rst_flush",  flush_cnt, 4'd0);
      check("rst_stall",  stall_o, 1'b0);
      rst_n = 1'b1;

      // Normal capture of a load.
      drive_id(CTRL_LW, 5'd29, 5'd8, 5'd0, 32'h0000_0104);
      tick();
      check("cap_ctrl",  ex_ctrl, CTRL_LW);
      check("cap_valid", ex_valid, 1'b1);
      check("cap_rt",    ex_rt, 5'd8);
      check("cap_pc4",   ex_pc4, 32'h0000_0104);
      check("cap_rsd",   ex_rs_data, 32'hA5A5_0104);
      check("cap_imm",   ex_imm, 16'h0114);

      // Load-use: add uses $8 right behind the lw.
      drive_id(CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h0000_0108);
      check("lu_stall", stall_o, 1'b1);
      tick();
      check("lu_bub_ctrl",  ex_ctrl, 22'h0);
      check("lu_bub_valid", ex_valid, 1'b0);
      check("lu_bub_cnt",   bubble_cnt, 4'd1);
      check("lu_bub_stall", stall_o, 1'b0);
      check("lu_bub_rs",    ex_rs, 5'd8);
      tick();
      check("lu_add_ctrl",  ex_ctrl, CTRL_ADD);
      check("lu_add_valid", ex_valid, 1'b1);
      check("lu_add_rd",    ex_rd, 5'd10);
      check("lu_add_cnt",   bubble_cnt, 4'd1);

      // Zero register never triggers a stall.
      drive_id(CTRL_LW, 5'd4, 5'd0, 5'd0, 32'h0000_0200);
      tick();
      drive_id(CTRL_ADD, 5'd0, 5'd0, 5'd11, 32'h0000_0204);
      check("z_stall", stall_o, 1'b0);
      tick();
      check("z_ctrl",  ex_ctrl, CTRL_ADD);
      check("z_valid", ex_valid, 1'b1);
      check("z_cnt",   bubble_cnt, 4'd1);

      // Flush beats a simultaneous hazard.
      drive_id(CTRL_LW, 5'd4, 5'd5, 5'd0, 32'h0000_0300);
      tick();
      flush_i = 1'b1;
      drive_id(CTRL_ADD, 5'd5, 5'd6, 5'd12, 32'h0000_0304);
      check("fl_stall", stall_o, 1'b0);
      tick();
      flush_i = 1'b0;
      check("fl_ctrl",   ex_ctrl, 22'h0);
      check("fl_valid",  ex_valid, 1'b0);
      check("fl_cnt",    flush_cnt, 4'd1);
      check("fl_bubble", bubble_cnt, 4'd1);
      check("fl_pc4",    ex_pc4, 32'h0000_0304);

      // Hold for three cycles with a hazard present and ID changing.
      drive_id(CTRL_LW, 5'd4, 5'd7, 5'd0, 32'h0000_0400);
      tick();
      hold_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(CTRL_ADD, 5'd7, 5'd1, 5'd13 + 5'(i), 32'h0000_0500 + 32'(i * 4));
         check("hd_stall", stall_o, 1'b1);
         tick();
         check("hd_ctrl",   ex_ctrl, CTRL_LW);
         check("hd_pc4",    ex_pc4, 32'h0000_0400);
         check("hd_valid",  ex_valid, 1'b1);
         check("hd_bubble", bubble_cnt, 4'd1);
         check("hd_flush",  flush_cnt, 4'd1);
      end
      hold_i = 1'b0;
      #1;
      check("hd_rel_stall", stall_o, 1'b1);
      tick();
      check("hd_rel_valid",  ex_valid, 1'b0);
      check("hd_rel_bubble", bubble_cnt, 4'd2);

      // Twenty more bubbles: counter must stick at 15.
      for (int i = 0; i < 20; i++) begin
         drive_id(CTRL_LW, 5'd4, 5'd3, 5'd0, 32'h0000_1000 + 32'(i * 8));
         tick();
         drive_id(CTRL_ADD, 5'd3, 5'd2, 5'd14, 32'h0000_1004 + 32'(i * 8));
         tick();
         if (i == 12) check("sat_at15", bubble_cnt, 4'd15);
      end
      check("sat_cnt",   bubble_cnt, 4'd15);
      check("sat_flush", flush_cnt, 4'd1);

      // Asynchronous reset mid-cycle with live EX contents.
      drive_id(CTRL_LW, 5'd4, 5'd9, 5'd0, 32'h0000_2000);
      tick();
      check("ar_pre_ctrl", ex_ctrl, CTRL_LW);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ctrl",   ex_ctrl, 22'h0);
      check("ar_valid",  ex_valid, 1'b0);
      check("ar_pc4",    ex_pc4, 32'h0);
      check("ar_rt",     ex_rt, 5'd0);
      check("ar_bubble", bubble_cnt, 4'd0);
      check("ar_flush",  flush_cnt, 4'd0);
      check("ar_stall",  stall_o, 1'b0);
      #1;
      rst_n = 1'b1;
      drive_id(CTRL_ADD, 5'd9, 5'd1, 5'd15, 32'h0000_2004);
      check("ar_rel_stall", stall_o, 1'b0);
      tick();
      check("ar_rel_ctrl",  ex_ctrl, CTRL_ADD);
      check("ar_rel_valid", ex_valid, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
